// File: rtl/ipa_ctx_pkg.sv
// Shared types for the IPA context loader: FSM state encoding and bank slice placement.
package ipa_ctx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StPush,
    StExec
  } state_e;

  // Bank 0 lands in the most-significant slice of the assembled context word.
  function automatic int unsigned ctx_slice_lsb(int unsigned bank, int unsigned nb_banks,
                                                int unsigned width);
    return (nb_banks - 1 - bank) * width;
  endfunction

endpackage

// File: rtl/ipa_ctx_bank_port.sv
// One GCM bank port: holds request until granted, then captures the returning read word once.
module ipa_ctx_bank_port #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_en_i,
  input  logic                  clear_i,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  req_o,
  output logic                  gnt_acc_o,
  output logic                  granted_o,
  output logic                  cap_now_o,
  output logic                  captured_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  granted_q;
  logic                  captured_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign req_o      = req_en_i & ~granted_q;
  assign gnt_acc_o  = req_o & gnt_i;
  // Only a bank granted in the current row may deliver data; stale returns are dropped.
  assign cap_now_o  = rvalid_i & granted_q & ~captured_q & ~clear_i;
  assign granted_o  = granted_q;
  assign captured_o = captured_q;
  assign data_o     = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted_q  <= 1'b0;
      captured_q <= 1'b0;
      data_q     <= '0;
    end else if (clear_i) begin
      granted_q  <= 1'b0;
      captured_q <= 1'b0;
    end else begin
      granted_q  <= granted_q | gnt_acc_o;
      captured_q <= captured_q | cap_now_o;
      if (cap_now_o) data_q <= rdata_i;
    end
  end

endmodule

// File: rtl/ipa_ctx_loader.sv
// Context-fetch engine: gathers one row per step from all GCM banks, streams it to the CGRA
// configuration port, then launches execution and waits for completion under a watchdog.
module ipa_ctx_loader
  import ipa_ctx_pkg::*;
#(
  parameter int unsigned NB_BANKS       = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_MEM_WIDTH = 12,
  parameter int unsigned CNT_WIDTH      = 10,
  parameter int unsigned NB_PE          = 16,
  parameter int unsigned WDOG_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic [ADDR_MEM_WIDTH-1:0]          base_row_i,
  input  logic [CNT_WIDTH-1:0]               nb_words_i,
  input  logic [WDOG_WIDTH-1:0]              wdog_limit_i,
  input  logic                               abort_i,
  output logic [NB_BANKS-1:0]                bank_req_o,
  output logic [NB_BANKS*ADDR_MEM_WIDTH-1:0] bank_add_o,
  input  logic [NB_BANKS-1:0]                bank_gnt_i,
  input  logic [NB_BANKS-1:0]                bank_rvalid_i,
  input  logic [NB_BANKS*DATA_WIDTH-1:0]     bank_rdata_i,
  output logic                               ctx_valid_o,
  output logic [CNT_WIDTH-1:0]               ctx_addr_o,
  output logic [NB_BANKS*DATA_WIDTH-1:0]     ctx_data_o,
  input  logic                               ctx_ready_i,
  output logic                               exec_en_o,
  input  logic [NB_PE-1:0]                   end_exec_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  state_e                    state_q, state_d;
  logic [ADDR_MEM_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]      nb_q, nb_d;
  logic [CNT_WIDTH-1:0]      idx_q, idx_d;
  logic [WDOG_WIDTH-1:0]     limit_q, limit_d;
  logic [WDOG_WIDTH-1:0]     wdog_q, wdog_d;
  logic                      exec_en_q, exec_en_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [NB_BANKS-1:0]       req, gnt_acc, granted, cap_now, captured;
  logic [DATA_WIDTH-1:0]     bank_data [NB_BANKS];
  logic [ADDR_MEM_WIDTH-1:0] row_addr;
  logic                      abort_act, handshake, clear, all_gnt, all_cap;

  assign abort_act = abort_i & (state_q != StIdle);
  assign handshake = (state_q == StPush) & ctx_ready_i;
  assign clear     = (state_q == StIdle) | abort_act | handshake;
  assign all_gnt   = &(granted | gnt_acc);
  assign all_cap   = &(captured | cap_now);
  assign row_addr  = base_q + ADDR_MEM_WIDTH'(idx_q);

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    localparam int unsigned DataLsb = ctx_slice_lsb(b, NB_BANKS, DATA_WIDTH);

    ipa_ctx_bank_port #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_port (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_en_i  (state_q == StReq),
      .clear_i   (clear),
      .gnt_i     (bank_gnt_i[b]),
      .rvalid_i  (bank_rvalid_i[b]),
      .rdata_i   (bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH]),
      .req_o     (req[b]),
      .gnt_acc_o (gnt_acc[b]),
      .granted_o (granted[b]),
      .cap_now_o (cap_now[b]),
      .captured_o(captured[b]),
      .data_o    (bank_data[b])
    );

    assign bank_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = req[b] ? row_addr : '0;
    assign ctx_data_o[DataLsb +: DATA_WIDTH] = ctx_valid_o ? bank_data[b] : '0;
  end

  assign bank_req_o  = req;
  assign ctx_valid_o = (state_q == StPush);
  assign ctx_addr_o  = ctx_valid_o ? idx_q : '0;
  assign busy_o      = (state_q != StIdle);
  assign exec_en_o   = exec_en_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nb_d      = nb_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    wdog_d    = wdog_q;
    exec_en_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (abort_act) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (nb_words_i != '0) begin
              base_d  = base_row_i;
              nb_d    = nb_words_i;
              limit_d = wdog_limit_i;
              idx_d   = '0;
              state_d = StReq;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StReq:  if (all_gnt) state_d = StResp;
        StResp: if (all_cap) state_d = StPush;
        StPush: begin
          if (ctx_ready_i) begin
            idx_d = idx_q + CNT_WIDTH'(1);
            if (idx_q == nb_q - CNT_WIDTH'(1)) begin
              state_d   = StExec;
              exec_en_d = 1'b1;
              wdog_d    = '0;
            end else begin
              state_d = StReq;
            end
          end
        end
        StExec: begin
          wdog_d = wdog_q + WDOG_WIDTH'(1);
          // A completion flag seen on the timeout cycle still counts as a clean finish.
          if (|end_exec_i) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else if ((limit_q != '0) && (wdog_q == limit_q)) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      nb_q      <= '0;
      idx_q     <= '0;
      limit_q   <= '0;
      wdog_q    <= '0;
      exec_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nb_q      <= nb_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      wdog_q    <= wdog_d;
      exec_en_q <= exec_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ipa_ctx_loader.sv
// Self-checking bench for ipa_ctx_loader with a behavioural GCM bank model and CGRA sink.
module tb_ipa_ctx_loader;

  localparam int NB = 2, DW = 32, AW = 12, CW = 10, NPE = 16, WW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [AW-1:0]     base_row_i = '0;
  logic [CW-1:0]     nb_words_i = '0;
  logic [WW-1:0]     wdog_limit_i = '0;
  logic              abort_i = 1'b0;
  logic [NB-1:0]     bank_req_o;
  logic [NB*AW-1:0]  bank_add_o;
  logic [NB-1:0]     bank_gnt_i;
  logic [NB-1:0]     bank_rvalid_i;
  logic [NB*DW-1:0]  bank_rdata_i;
  logic              ctx_valid_o;
  logic [CW-1:0]     ctx_addr_o;
  logic [NB*DW-1:0]  ctx_data_o;
  logic              ctx_ready_i = 1'b0;
  logic              exec_en_o;
  logic [NPE-1:0]    end_exec_i = '0;
  logic              busy_o, done_o, err_o;

  ipa_ctx_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_row_i   (base_row_i),
    .nb_words_i   (nb_words_i),
    .wdog_limit_i (wdog_limit_i),
    .abort_i      (abort_i),
    .bank_req_o   (bank_req_o),
    .bank_add_o   (bank_add_o),
    .bank_gnt_i   (bank_gnt_i),
    .bank_rvalid_i(bank_rvalid_i),
    .bank_rdata_i (bank_rdata_i),
    .ctx_valid_o  (ctx_valid_o),
    .ctx_addr_o   (ctx_addr_o),
    .ctx_data_o   (ctx_data_o),
    .ctx_ready_i  (ctx_ready_i),
    .exec_en_o    (exec_en_o),
    .end_exec_i   (end_exec_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] salt = 32'h0;

  // Bank model configuration and state
  int  gnt_dly_cfg [NB];
  bit  gnt_rand = 1'b0;
  int  cur_dly [NB];
  int  req_age [NB];
  int  rv_lat [NB];
  int  tmr [NB];
  logic [DW-1:0] pend [NB];
  logic [NB-1:0] rv_r = '0;
  logic [NB*DW-1:0] rd_r = '0;
  logic [NB-1:0] gnt_c;

  // Sink configuration and per-load observations
  int stall_n = 0;
  bit rdy_rand = 1'b0;
  int req_seen [NB];
  int valid_seen = 0;
  int load_cyc = 0;

  function automatic logic [DW-1:0] mem_word(int b, logic [AW-1:0] row);
    return salt ^ {4'(b + 1), 16'h0, row} ^ (32'(row) << 17);
  endfunction

  function automatic logic [NB*DW-1:0] exp_word(logic [AW-1:0] row);
    logic [NB*DW-1:0] w;
    w = '0;
    for (int b = 0; b < NB; b++) w[(NB-1-b)*DW +: DW] = mem_word(b, row);
    return w;
  endfunction

  always_comb begin
    gnt_c = '0;
    for (int b = 0; b < NB; b++) gnt_c[b] = bank_req_o[b] && (req_age[b] >= cur_dly[b]);
  end
  assign bank_gnt_i    = gnt_c;
  assign bank_rvalid_i = rv_r;
  assign bank_rdata_i  = rd_r;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_req_o[b] && gnt_c[b]) begin
        req_age[b] <= 0;
        if (rv_lat[b] <= 1) begin
          rv_r[b]            <= 1'b1;
          rd_r[b*DW +: DW]   <= mem_word(b, bank_add_o[b*AW +: AW]);
        end else begin
          rv_r[b] <= 1'b0;
          tmr[b]  <= rv_lat[b] - 1;
          pend[b] <= mem_word(b, bank_add_o[b*AW +: AW]);
        end
      end else begin
        if (bank_req_o[b]) req_age[b] <= req_age[b] + 1;
        else begin
          req_age[b] <= 0;
          cur_dly[b] <= gnt_rand ? int'($urandom_range(0, 3)) : gnt_dly_cfg[b];
        end
        if (tmr[b] == 1) begin
          rv_r[b]          <= 1'b1;
          rd_r[b*DW +: DW] <= pend[b];
        end else begin
          rv_r[b] <= 1'b0;
        end
        if (tmr[b] != 0) tmr[b] <= tmr[b] - 1;
      end
    end
  end

  // Starts a load at the current negedge and streams all rows; returns on the first EXEC cycle.
  task automatic load(input logic [AW-1:0] base, input int nb, input logic [WW-1:0] lim);
    int idx;
    int cyc;
    logic [AW-1:0] row;
    idx = 0;
    req_seen = '{default: 0};
    valid_seen = 0;
    start_i = 1'b1;
    base_row_i = base;
    nb_words_i = CW'(nb);
    wdog_limit_i = lim;
    ctx_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", busy_o);
    end
    while (idx < nb && cyc < 400) begin
      row = base + AW'(idx);
      for (int b = 0; b < NB; b++) begin
        if (bank_req_o[b]) begin
          req_seen[b]++;
          total++;
          if (bank_add_o[b*AW +: AW] !== row) begin
            bad++;
            $display("FAIL bank_add[%0d]: got %h want %h", b, bank_add_o[b*AW +: AW], row);
          end
        end
      end
      if (ctx_valid_o) begin
        valid_seen++;
        total++;
        if (ctx_addr_o !== CW'(idx) || ctx_data_o !== exp_word(row)) begin
          bad++;
          $display("FAIL ctx_word: got addr=%0d data=%h want addr=%0d data=%h",
                   ctx_addr_o, ctx_data_o, idx, exp_word(row));
        end
        total++;
        if (bank_req_o !== '0) begin
          bad++;
          $display("FAIL req_during_push: got %b want 0", bank_req_o);
        end
        if (stall_n > 0) begin
          ctx_ready_i = 1'b0;
          stall_n--;
        end else begin
          ctx_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (ctx_ready_i) idx++;
      end else begin
        ctx_ready_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    ctx_ready_i = 1'b0;
    if (idx < nb) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got %0d words want %0d", idx, nb);
    end
    load_cyc = cyc;
  endtask

  // Called on the first EXEC cycle; end_at < 0 means no completion flag.
  task automatic exec_phase(input int lim, input int end_at, input int pe);
    int stop_k;
    bit exp_err;
    if (lim != 0 && (end_at < 0 || end_at > lim)) begin
      stop_k = lim;
      exp_err = 1'b1;
    end else begin
      stop_k = end_at;
      exp_err = 1'b0;
    end
    for (int k = 0; k <= stop_k; k++) begin
      total++;
      if (exec_en_o !== (k == 0)) begin
        bad++;
        $display("FAIL exec_en k=%0d: got %b want %b", k, exec_en_o, (k == 0));
      end
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL exec_busy k=%0d: got done=%b busy=%b want done=0 busy=1", k, done_o, busy_o);
      end
      end_exec_i = (k == end_at) ? (NPE'(1) << pe) : '0;
      @(negedge clk);
    end
    end_exec_i = '0;
    total++;
    if (done_o !== 1'b1 || err_o !== exp_err || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL exec_end: got done=%b err=%b busy=%b want done=1 err=%b busy=0",
               done_o, err_o, busy_o, exp_err);
    end
    @(negedge clk);
    total++;
    if (done_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width: got done=%b err=%b want 0 0", done_o, err_o);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({busy_o, done_o, err_o, exec_en_o, ctx_valid_o} !== 5'b0) begin
        bad++;
        $display("FAIL reset_flags: got %b want 00000",
                 {busy_o, done_o, err_o, exec_en_o, ctx_valid_o});
      end
      total++;
      if (bank_req_o !== '0 || bank_add_o !== '0 || ctx_data_o !== '0 || ctx_addr_o !== '0) begin
        bad++;
        $display("FAIL reset_buses: got req=%b add=%h data=%h addr=%0d want 0",
                 bank_req_o, bank_add_o, ctx_data_o, ctx_addr_o);
      end
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    load(12'h010, 3, '0);
    total++;
    if (load_cyc !== 10) begin
      bad++;
      $display("FAIL row_latency: got %0d cycles want 10", load_cyc);
    end
    exec_phase(0, 2, 5);
  endtask

  task automatic test_gnt_skew();
    gnt_dly_cfg[1] = 4;
    @(negedge clk);
    load(12'h3A0, 1, '0);
    total++;
    if (req_seen[0] !== 1 || req_seen[1] !== 5 || valid_seen !== 1) begin
      bad++;
      $display("FAIL gnt_skew: got req0=%0d req1=%0d valid=%0d want 1 5 1",
               req_seen[0], req_seen[1], valid_seen);
    end
    exec_phase(0, 0, 0);
    gnt_dly_cfg[1] = 0;
  endtask

  task automatic test_ready_stall();
    stall_n = 5;
    load(12'h222, 2, '0);
    total++;
    if (valid_seen !== 7) begin
      bad++;
      $display("FAIL ready_stall: got %0d valid cycles want 7", valid_seen);
    end
    exec_phase(0, 1, 15);
  endtask

  task automatic test_zero_len();
    start_i = 1'b1;
    nb_words_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || bank_req_o !== '0) begin
      bad++;
      $display("FAIL zero_len: got err=%b busy=%b done=%b req=%b want 1 0 0 0",
               err_o, busy_o, done_o, bank_req_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || bank_req_o !== '0) begin
        bad++;
        $display("FAIL zero_len_after: got err=%b busy=%b req=%b want 0 0 0",
                 err_o, busy_o, bank_req_o);
      end
    end
  endtask

  task automatic test_wdog();
    load(12'h050, 1, 16'd8);
    exec_phase(8, -1, 0);
    load(12'h051, 2, 16'd8);
    exec_phase(8, 8, 3);
    load(12'h052, 1, 16'd8);
    exec_phase(8, 4, 9);
  endtask

  task automatic test_abort();
    rv_lat[1] = 3;
    start_i = 1'b1;
    base_row_i = 12'h040;
    nb_words_i = CW'(2);
    wdog_limit_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b1 || bank_req_o !== '0 || ctx_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_setup: got busy=%b req=%b valid=%b want 1 0 0",
               busy_o, bank_req_o, ctx_valid_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    rv_lat[1] = 1;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b1 || err_o !== 1'b0 || ctx_valid_o !== 1'b0 ||
        bank_req_o !== '0) begin
      bad++;
      $display("FAIL abort: got busy=%b done=%b err=%b valid=%b req=%b want 0 1 0 0 0",
               busy_o, done_o, err_o, ctx_valid_o, bank_req_o);
    end
    load(12'h000, 2, '0);
    exec_phase(0, 1, 7);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got done=%b busy=%b want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    int nb, lim, end_at;
    gnt_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      base = (it % 2 == 0) ? AW'(12'hFFE - AW'($urandom_range(0, 2))) : AW'($urandom);
      nb = int'($urandom_range(1, 5));
      lim = int'($urandom_range(0, 6));
      end_at = int'($urandom_range(0, 9)) - 1;
      if (lim == 0 && end_at < 0) end_at = 3;
      @(negedge clk);
      load(base, nb, WW'(lim));
      exec_phase(lim, end_at, int'($urandom_range(0, NPE - 1)));
    end
    gnt_rand = 1'b0;
    rdy_rand = 1'b0;
  endtask

  initial begin
    salt = $urandom;
    for (int b = 0; b < NB; b++) begin
      gnt_dly_cfg[b] = 0;
      cur_dly[b] = 0;
      req_age[b] = 0;
      rv_lat[b] = 1;
      tmr[b] = 0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_gnt_skew();
    test_ready_stall();
    test_zero_len();
    test_wdog();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipa_ctx_loader.md
Name: ipa_ctx_loader

Overview:
Parametrised context-fetch engine for the IPA CGRA. Reads a context image of programmable length from NB_BANKS interleaved GCM SRAM banks and assembles one NB_BANKS*DATA_WIDTH word per row. Streams the words into the CGRA configuration port over valid/ready, then launches execution and tracks completion with a watchdog. Replaces the fixed 2-bank, forced-request fetch path with a grant-based, length-programmable, abortable engine.

Parameters:
NB_BANKS, 2, number of GCM banks fetched in parallel per context row
DATA_WIDTH, 32, bits per bank word
ADDR_MEM_WIDTH, 12, bank row address width
CNT_WIDTH, 10, width of context word count
NB_PE, 16, number of PE end-of-execution flags (NB_ROWS*NB_COLS)
WDOG_WIDTH, 16, execution watchdog counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to load and execute a context
base_row_i  in  ADDR_MEM_WIDTH  first bank row of context image
nb_words_i  in  CNT_WIDTH  context rows to load
wdog_limit_i  in  WDOG_WIDTH  exec timeout in cycles; 0 disables watchdog
abort_i  in  1  cancel current operation
bank_req_o  out  NB_BANKS  per-bank request
bank_add_o  out  NB_BANKS*ADDR_MEM_WIDTH  per-bank row address
bank_gnt_i  in  NB_BANKS  per-bank grant
bank_rvalid_i  in  NB_BANKS  per-bank read-data valid
bank_rdata_i  in  NB_BANKS*DATA_WIDTH  per-bank read data
ctx_valid_o  out  1  context word valid
ctx_addr_o  out  CNT_WIDTH  context word index (0-based)
ctx_data_o  out  NB_BANKS*DATA_WIDTH  context word; bank 0 in MS slice
ctx_ready_i  in  1  CGRA accepts context word
exec_en_o  out  1  one-cycle execute pulse
end_exec_i  in  NB_PE  per-PE end-of-execution flags
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle error pulse (zero length or watchdog)

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters and capture buffer cleared.
- FSM states: IDLE, REQ, RESP, PUSH, EXEC.
- IDLE: start_i with nb_words_i != 0 latches base_row_i/nb_words_i/wdog_limit_i, sets busy_o next cycle, goes to REQ. start_i with nb_words_i == 0: err_o pulse next cycle, stays IDLE, busy_o stays 0. start_i while busy_o=1 is ignored.
- REQ: bank_req_o[b]=1 and bank_add_o[b]=base_row + idx for every bank not yet granted. Each bank drops its request the cycle after its own grant; a granted-mask tracks them. Banks may grant in different cycles. Go to RESP when all banks are granted.
- RESP: capture bank_rdata_i[b] on bank_rvalid_i[b]; rvalid arrives one cycle after grant, possibly in the same cycle as a later bank's grant. When all banks are captured, go to PUSH.
- PUSH: ctx_valid_o=1; ctx_data_o and ctx_addr_o=idx are stable until ctx_ready_i. On handshake, idx+1. If idx was nb_words-1, go to EXEC and pulse exec_en_o the same cycle as the transition. Otherwise clear the masks and go to REQ.
- Minimum per-row latency with gnt and ready always high: 3 cycles (REQ, RESP, PUSH).
- EXEC: the watchdog counts up from 0. If the OR-reduction of end_exec_i is 1, pulse done_o, clear busy_o, go to IDLE. If wdog_limit != 0 and the count reaches wdog_limit with no end flag, pulse done_o and err_o together, clear busy_o, go to IDLE. If end flag and limit occur in the same cycle, the end flag wins and err_o is not asserted.
- abort_i in any non-IDLE state: next cycle FSM is IDLE, all req/valid outputs are 0, busy_o is 0, done_o is pulsed. rvalid arriving after abort is discarded. abort_i in IDLE has no effect.
- idx and base_row+idx are modulo-2^width; row wrap-around is legal and not flagged.

Decomposition:
- Package ipa_ctx_pkg: FSM state enum and bank-slice index helper constants.
- Sub-module ipa_ctx_bank_port, one instance per bank: request/grant-mask flop, rvalid capture register, captured flag, clear input.

Test Plan:
- nb_words=3, base_row=0x10, gnt/ready tied 1 -> addresses 0x10/0x11/0x12 on both banks; ctx_addr 0,1,2 with data {bank0,bank1}; exec_en 1 cycle after last handshake; end_exec_i[5]=1 -> done_o pulse, busy_o=0.
- bank1 gnt delayed 4 cycles, bank0 immediate -> bank0 req drops after its grant, bank1 req held 4 cycles, single ctx_valid with both words correct.
- ctx_ready_i low for 5 cycles -> ctx_valid/data/addr stable for 5 cycles, no new bank_req_o until handshake.
- start_i with nb_words_i=0 -> err_o 1-cycle pulse, busy_o stays 0, no bank_req_o.
- wdog_limit=8, end_exec_i all 0 -> done_o and err_o pulse 8 cycles into EXEC; a repeat with end flag at cycle 8 -> done_o only.
- abort_i asserted mid-RESP, then a new start -> busy_o drops next cycle, done_o pulses, the stale rvalid is ignored, and the new run loads correct data from row 0.
